calendar_bcd_ext: RTL and testbench

//  Parametrised BCD date counter (day/month/year) driven by the day-carry of the

---
 rtl/calendar_bcd_ext.sv | 172 +++++++++++++++++
 tb/tb_calendar_bcd_ext.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/calendar_bcd_ext.sv
// BCD day/month/year counter advanced by the time-of-day day carry, with manual per-field inc/dec.
// Latency: Data/leap/year_wrap are registered one cycle behind the internal date counters.
// No backpressure: a day_tick during a manual edit is queued (depth one) and applied on the next free cycle.
module calendar_bcd_ext #(
  parameter int          YEAR_DIGITS = 2,
  parameter logic [15:0] RESET_YEAR  = 16'h2000,
  parameter int          GREGORIAN   = 1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       day_tick,
  input  logic [2:0]                 cnt_inc,
  input  logic [2:0]                 cnt_dec,
  output logic [15+4*YEAR_DIGITS:0]  Data,
  output logic                       leap,
  output logic                       year_wrap
);

  localparam int            YW       = 4 * YEAR_DIGITS;
  localparam logic [YW-1:0] YEAR_MAX = {YEAR_DIGITS{4'h9}};
  localparam logic [YW-1:0] YEAR_RST = RESET_YEAR[YW-1:0];

  // Two-digit BCD +1 / -1 (callers handle the field-specific wrap points).
  function automatic logic [7:0] bcd2_inc(input logic [7:0] x);
    return (x[3:0] == 4'd9) ? {x[7:4] + 4'd1, 4'd0} : {x[7:4], x[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd2_dec(input logic [7:0] x);
    return (x[3:0] == 4'd0) ? {x[7:4] - 4'd1, 4'd9} : {x[7:4], x[3:0] - 4'd1};
  endfunction

  // Year ripple increment/decrement; overflow past all-nines wraps to zero and vice versa.
  function automatic logic [YW-1:0] year_inc(input logic [YW-1:0] y);
    logic [YW-1:0] r;
    logic          c;
    r = y;
    c = 1'b1;
    for (int i = 0; i < YEAR_DIGITS; i++) begin
      if (c) begin
        if (y[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = y[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [YW-1:0] year_dec(input logic [YW-1:0] y);
    logic [YW-1:0] r;
    logic          b;
    r = y;
    b = 1'b1;
    for (int i = 0; i < YEAR_DIGITS; i++) begin
      if (b) begin
        if (y[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = y[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Two BCD digits divisible by 4: even tens needs units 0/4/8, odd tens needs 2/6.
  function automatic logic div4(input logic [7:0] two);
    if (two[4]) return (two[3:0] == 4'd2) || (two[3:0] == 4'd6);
    else        return (two[3:0] == 4'd0) || (two[3:0] == 4'd4) || (two[3:0] == 4'd8);
  endfunction

  function automatic logic is_leap(input logic [YW-1:0] y);
    logic [15:0] y16;
    y16 = 16'(y);
    if (GREGORIAN != 0 && YEAR_DIGITS == 4 && y16[7:0] == 8'h00) return div4(y16[15:8]);
    else                                                        return div4(y16[7:0]);
  endfunction

  function automatic logic [7:0] days_in(input logic [7:0] m, input logic lp);
    case (m)
      8'h02:                      return lp ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  logic [7:0]    day_q, mon_q, day_n, mon_n, last_n, day_op;
  logic [YW-1:0] year_q, year_n;
  logic          pend_q, pend_n, wrap_q, wrap_n;
  logic          manual;
  logic          d_inc, d_dec, m_inc, m_dec, y_inc, y_dec;

  assign manual = |{cnt_inc, cnt_dec};
  assign d_inc  = cnt_inc[0] & ~cnt_dec[0];
  assign d_dec  = cnt_dec[0] & ~cnt_inc[0];
  assign m_inc  = cnt_inc[1] & ~cnt_dec[1];
  assign m_dec  = cnt_dec[1] & ~cnt_inc[1];
  assign y_inc  = cnt_inc[2] & ~cnt_dec[2];
  assign y_dec  = cnt_dec[2] & ~cnt_inc[2];

  // Next date: manual edits take priority over ticks; ticks seen during edits are queued.
  always_comb begin
    day_n  = day_q;
    mon_n  = mon_q;
    year_n = year_q;
    pend_n = pend_q;
    wrap_n = 1'b0;
    last_n = days_in(mon_q, is_leap(year_q));
    day_op = day_q;
    if (manual) begin
      if (y_inc)      year_n = year_inc(year_q);
      else if (y_dec) year_n = year_dec(year_q);
      if (m_inc)      mon_n = (mon_q == 8'h12) ? 8'h01 : bcd2_inc(mon_q);
      else if (m_dec) mon_n = (mon_q == 8'h01) ? 8'h12 : bcd2_dec(mon_q);
      // Day edits see the month/year as they will be after this update.
      last_n = days_in(mon_n, is_leap(year_n));
      if (d_inc)      day_op = (day_q >= last_n) ? 8'h01 : bcd2_inc(day_q);
      else if (d_dec) day_op = (day_q == 8'h01) ? last_n : bcd2_dec(day_q);
      day_n  = (day_op > last_n) ? last_n : day_op;
      pend_n = pend_q | day_tick;
    end else if (day_tick | pend_q) begin
      // A fresh tick on top of a queued one applies one and keeps the other queued.
      pend_n = day_tick & pend_q;
      if (day_q >= last_n) begin
        day_n = 8'h01;
        if (mon_q == 8'h12) begin
          mon_n  = 8'h01;
          year_n = year_inc(year_q);
          wrap_n = (year_q == YEAR_MAX);
        end else begin
          mon_n = bcd2_inc(mon_q);
        end
      end else begin
        day_n = bcd2_inc(day_q);
      end
    end
  end

  // Date counters, tick queue and wrap flag.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      day_q  <= 8'h01;
      mon_q  <= 8'h01;
      year_q <= YEAR_RST;
      pend_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      day_q  <= day_n;
      mon_q  <= mon_n;
      year_q <= year_n;
      pend_q <= pend_n;
      wrap_q <= wrap_n;
    end
  end

  // Registered outputs, one cycle behind the counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Data      <= {8'h01, 8'h01, YEAR_RST};
      leap      <= is_leap(YEAR_RST);
      year_wrap <= 1'b0;
    end else begin
      Data      <= {day_q, mon_q, year_q};
      leap      <= is_leap(year_q);
      year_wrap <= wrap_q;
    end
  end

endmodule

// File: tb/tb_calendar_bcd_ext.sv
module tb_calendar_bcd_ext;

  logic        Clk;
  logic        Reset;
  logic        day_tick;
  logic [2:0]  cnt_inc;
  logic [2:0]  cnt_dec;
  logic [31:0] Data;
  logic        leap;
  logic        year_wrap;

  int n_cmp = 0;
  int n_bad = 0;

  calendar_bcd_ext #(
    .YEAR_DIGITS(4),
    .RESET_YEAR (16'h2000),
    .GREGORIAN  (1)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .day_tick (day_tick),
    .cnt_inc  (cnt_inc),
    .cnt_dec  (cnt_dec),
    .Data     (Data),
    .leap     (leap),
    .year_wrap(year_wrap)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    string      name;
    int         sd, sm, sy;
    logic [2:0] inc, dec;
    logic       tick;
    int         ed, em, ey;
    logic       eleap;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  function automatic logic [31:0] date_bcd(input int d, input int m, input int y);
    return {4'(d / 10), 4'(d % 10), 4'(m / 10), 4'(m % 10),
            4'(y / 1000), 4'((y / 100) % 10), 4'((y / 10) % 10), 4'(y % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; holds the given inputs across one rising edge.
  task automatic pulse(input logic [2:0] i, input logic [2:0] d, input logic t);
    cnt_inc  = i;
    cnt_dec  = d;
    day_tick = t;
    @(negedge Clk);
    cnt_inc  = 3'b000;
    cnt_dec  = 3'b000;
    day_tick = 1'b0;
  endtask

  // Reset to 01-01-2000, then walk the fields by manual steps; Data is valid on return.
  task automatic goto_date(input int d, input int m, input int y);
    int up, dn;
    Reset = 1'b1;
    cnt_inc = 3'b000;
    cnt_dec = 3'b000;
    day_tick = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    up = (y - 2000 + 10000) % 10000;
    dn = (2000 - y + 10000) % 10000;
    if (up <= dn) repeat (up) pulse(3'b100, 3'b000, 1'b0);
    else          repeat (dn) pulse(3'b000, 3'b100, 1'b0);
    repeat (m - 1) pulse(3'b010, 3'b000, 1'b0);
    repeat (d - 1) pulse(3'b001, 3'b000, 1'b0);
    @(negedge Clk);
  endtask

  initial begin
    Reset    = 1'b1;
    day_tick = 1'b0;
    cnt_inc  = 3'b000;
    cnt_dec  = 3'b000;

    //          name           sd  sm  sy    inc     dec     tick  ed  em  ey    leap
    vt[0]  = '{"tick_1900",    28,  2, 1900, 3'b000, 3'b000, 1'b1,  1,  3, 1900, 1'b0};
    vt[1]  = '{"tick_2000",    28,  2, 2000, 3'b000, 3'b000, 1'b1, 29,  2, 2000, 1'b1};
    vt[2]  = '{"tick_2100",    28,  2, 2100, 3'b000, 3'b000, 1'b1,  1,  3, 2100, 1'b0};
    vt[3]  = '{"tick_newyear", 31, 12, 2023, 3'b000, 3'b000, 1'b1,  1,  1, 2024, 1'b1};
    vt[4]  = '{"tick_30day",   30,  4, 2023, 3'b000, 3'b000, 1'b1,  1,  5, 2023, 1'b0};
    vt[5]  = '{"mon_clamp",    31,  1, 2023, 3'b010, 3'b000, 1'b0, 28,  2, 2023, 1'b0};
    vt[6]  = '{"year_clamp",   29,  2, 2024, 3'b100, 3'b000, 1'b0, 28,  2, 2025, 1'b0};
    vt[7]  = '{"day_dec_01",    1,  5, 2024, 3'b000, 3'b001, 1'b0, 31,  5, 2024, 1'b1};
    vt[8]  = '{"mon_dec_01",   15,  1, 2024, 3'b000, 3'b010, 1'b0, 15, 12, 2024, 1'b1};
    vt[9]  = '{"day_inc_last", 30,  6, 2024, 3'b001, 3'b000, 1'b0,  1,  6, 2024, 1'b1};
    vt[10] = '{"mon_dec_clmp", 31,  3, 2024, 3'b000, 3'b010, 1'b0, 29,  2, 2024, 1'b1};
    vt[11] = '{"day_incdec",   10,  5, 2024, 3'b001, 3'b001, 1'b0, 10,  5, 2024, 1'b1};
    vt[12] = '{"year_dec_0",   15,  3,    0, 3'b000, 3'b100, 1'b0, 15,  3, 9999, 1'b0};
    vt[13] = '{"year_dec_clp", 29,  2,    0, 3'b000, 3'b100, 1'b0, 28,  2, 9999, 1'b0};
    vt[14] = '{"mon_yr_both",  31,  1, 2023, 3'b110, 3'b000, 1'b0, 29,  2, 2024, 1'b1};
    vt[15] = '{"day_dec_mar",   1,  3, 2024, 3'b000, 3'b001, 1'b0, 31,  3, 2024, 1'b1};
    vt[16] = '{"day_dec_feb",   1,  2, 2023, 3'b000, 3'b001, 1'b0, 28,  2, 2023, 1'b0};

    // Reset state
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("reset_data", Data, date_bcd(1, 1, 2000));
    chk("reset_leap", 32'(leap), 32'd1);
    chk("reset_wrap", 32'(year_wrap), 32'd0);

    // Table of single-cycle operations
    for (int k = 0; k < NV; k++) begin
      goto_date(vt[k].sd, vt[k].sm, vt[k].sy);
      chk({vt[k].name, "_start"}, Data, date_bcd(vt[k].sd, vt[k].sm, vt[k].sy));
      pulse(vt[k].inc, vt[k].dec, vt[k].tick);
      @(negedge Clk);
      chk({vt[k].name, "_data"}, Data, date_bcd(vt[k].ed, vt[k].em, vt[k].ey));
      chk({vt[k].name, "_leap"}, 32'(leap), 32'(vt[k].eleap));
      chk({vt[k].name, "_wrap"}, 32'(year_wrap), 32'd0);
    end

    // Max-year rollover: one-cycle wrap pulse
    goto_date(31, 12, 9999);
    chk("wrap_start", Data, date_bcd(31, 12, 9999));
    pulse(3'b000, 3'b000, 1'b1);
    @(negedge Clk);
    chk("wrap_data", Data, date_bcd(1, 1, 0));
    chk("wrap_pulse", 32'(year_wrap), 32'd1);
    chk("wrap_leap", 32'(leap), 32'd1);
    @(negedge Clk);
    chk("wrap_clear", 32'(year_wrap), 32'd0);

    // Tick deferred behind a year edit
    goto_date(10, 6, 2024);
    pulse(3'b100, 3'b000, 1'b1);
    @(negedge Clk);
    chk("defer_first", Data, date_bcd(10, 6, 2025));
    @(negedge Clk);
    chk("defer_second", Data, date_bcd(11, 6, 2025));
    repeat (2) @(negedge Clk);
    chk("defer_settle", Data, date_bcd(11, 6, 2025));

    // Second tick during edits overflows the one-deep queue
    goto_date(10, 6, 2024);
    pulse(3'b100, 3'b000, 1'b1);
    pulse(3'b100, 3'b000, 1'b1);
    repeat (3) @(negedge Clk);
    chk("defer_overflow", Data, date_bcd(11, 6, 2026));

    // Queued tick plus a fresh tick in a free cycle: both eventually apply
    goto_date(10, 6, 2024);
    pulse(3'b100, 3'b000, 1'b1);
    pulse(3'b000, 3'b000, 1'b1);
    repeat (3) @(negedge Clk);
    chk("defer_plus_tick", Data, date_bcd(12, 6, 2025));

    // Reset discards a queued tick
    goto_date(1, 1, 2000);
    cnt_inc  = 3'b100;
    day_tick = 1'b1;
    @(negedge Clk);
    cnt_inc  = 3'b000;
    day_tick = 1'b0;
    Reset    = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_drops_pend", Data, date_bcd(1, 1, 2000));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
